watchdog_recovery_ctrl: RTL and testbench

Supervisory controller that sequences the watchdog and recovers the monitored clock subsystem (counters, display mux) when the watchdog barks. It holds the watchdog in reset while disabled and arms it on enable. On each bark it runs a bounded reset-and-grace recovery sequence. It counts consecutive recoveries and latches a fault after too many; the display layer shows that fault.

---
 rtl/watchdog_recovery_ctrl.sv | 167 ++++++++++++++++
 tb/tb_watchdog_recovery_ctrl.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/watchdog_recovery_ctrl.sv
// rtl/watchdog_recovery_ctrl.sv - watchdog sequencing and bounded subsystem recovery controller
//
// Holds the watchdog in reset while disabled, arms it on enable, and on each
// bark runs a reset-then-grace recovery of the monitored subsystem. Consecutive
// recoveries are counted; one bark too many latches a sticky fault.
//
// Ports:
//   clk          system clock, all logic on posedge
//   reset        synchronous active-high reset
//   enable       1 = supervise, 0 = park in IDLE
//   bark         watchdog bark, pulse or level
//   clear_fault  level, leaves FAULT
//   wd_reset     registered reset to the watchdog
//   subsys_reset registered reset to the monitored subsystem
//   fault        registered sticky fault flag
//   retry_count  registered recoveries since the last healthy period

module watchdog_recovery_ctrl #(
    parameter int RESET_CYCLES   = 4,
    parameter int GRACE_CYCLES   = 16,
    parameter int MAX_RETRIES    = 3,
    parameter int HEALTHY_CYCLES = 1000,
    parameter int RETRY_WIDTH    = $clog2(MAX_RETRIES + 1)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic                   bark,
    input  logic                   clear_fault,
    output logic                   wd_reset,
    output logic                   subsys_reset,
    output logic                   fault,
    output logic [RETRY_WIDTH-1:0] retry_count
);

    localparam int PHASE_MAX = (RESET_CYCLES > GRACE_CYCLES) ? RESET_CYCLES : GRACE_CYCLES;
    localparam int TIMER_W   = $clog2(PHASE_MAX) + 1;
    localparam int HEALTHY_W = $clog2(HEALTHY_CYCLES) + 1;

    // Phase timer counts 0..N-1 inside a phase, so the last cycle is N-1.
    localparam logic [TIMER_W-1:0]     RESET_LAST   = TIMER_W'(RESET_CYCLES - 1);
    localparam logic [TIMER_W-1:0]     GRACE_LAST   = TIMER_W'(GRACE_CYCLES - 1);
    localparam logic [TIMER_W-1:0]     TIMER_ONE    = TIMER_W'(1);
    localparam logic [HEALTHY_W-1:0]   HEALTHY_LAST = HEALTHY_W'(HEALTHY_CYCLES - 1);
    localparam logic [HEALTHY_W-1:0]   HEALTHY_ONE  = HEALTHY_W'(1);
    localparam logic [RETRY_WIDTH-1:0] RETRY_MAX    = RETRY_WIDTH'(MAX_RETRIES);
    localparam logic [RETRY_WIDTH-1:0] RETRY_ONE    = RETRY_WIDTH'(1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_MONITOR = 3'd1,
        S_RECOVER = 3'd2,
        S_GRACE   = 3'd3,
        S_FAULT   = 3'd4
    } state_e;

    state_e                 state_q;
    logic                   wd_reset_q;
    logic                   subsys_reset_q;
    logic                   fault_q;
    logic [RETRY_WIDTH-1:0] retry_q;
    logic [TIMER_W-1:0]     timer_q;
    logic [HEALTHY_W-1:0]   healthy_q;

    // Outputs are set on the edge that enters each state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= S_IDLE;
            wd_reset_q     <= 1'b1;
            subsys_reset_q <= 1'b0;
            fault_q        <= 1'b0;
            retry_q        <= '0;
            timer_q        <= '0;
            healthy_q      <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    healthy_q <= '0;
                    if (enable) begin
                        state_q    <= S_MONITOR;
                        wd_reset_q <= 1'b0;
                    end
                end

                S_MONITOR: begin
                    if (bark) begin
                        // A bark wins over a healthy-period clear in the same cycle.
                        healthy_q      <= '0;
                        wd_reset_q     <= 1'b1;
                        subsys_reset_q <= 1'b1;
                        if (retry_q == RETRY_MAX) begin
                            state_q <= S_FAULT;
                            fault_q <= 1'b1;
                        end else begin
                            state_q <= S_RECOVER;
                            retry_q <= retry_q + RETRY_ONE;
                            timer_q <= '0;
                        end
                    end else if (!enable) begin
                        state_q    <= S_IDLE;
                        wd_reset_q <= 1'b1;
                        retry_q    <= '0;
                        healthy_q  <= '0;
                    end else if (healthy_q == HEALTHY_LAST) begin
                        // This cycle completes a full bark-free period.
                        healthy_q <= '0;
                        retry_q   <= '0;
                    end else begin
                        healthy_q <= healthy_q + HEALTHY_ONE;
                    end
                end

                S_RECOVER: begin
                    if (timer_q == RESET_LAST) begin
                        state_q        <= S_GRACE;
                        subsys_reset_q <= 1'b0;
                        timer_q        <= '0;
                    end else begin
                        timer_q <= timer_q + TIMER_ONE;
                    end
                end

                S_GRACE: begin
                    // enable is only consulted here, so disabling never cuts a recovery short.
                    if (timer_q == GRACE_LAST) begin
                        timer_q   <= '0;
                        healthy_q <= '0;
                        if (enable) begin
                            state_q    <= S_MONITOR;
                            wd_reset_q <= 1'b0;
                        end else begin
                            state_q <= S_IDLE;
                            retry_q <= '0;
                        end
                    end else begin
                        timer_q <= timer_q + TIMER_ONE;
                    end
                end

                S_FAULT: begin
                    if (clear_fault) begin
                        state_q        <= S_IDLE;
                        subsys_reset_q <= 1'b0;
                        fault_q        <= 1'b0;
                        retry_q        <= '0;
                    end
                end

                default: begin
                    state_q        <= S_IDLE;
                    wd_reset_q     <= 1'b1;
                    subsys_reset_q <= 1'b0;
                    fault_q        <= 1'b0;
                    retry_q        <= '0;
                    timer_q        <= '0;
                    healthy_q      <= '0;
                end
            endcase
        end
    end

    assign wd_reset     = wd_reset_q;
    assign subsys_reset = subsys_reset_q;
    assign fault        = fault_q;
    assign retry_count  = retry_q;

endmodule

// File: tb/tb_watchdog_recovery_ctrl.sv
// tb/tb_watchdog_recovery_ctrl.sv - self-checking bench for watchdog_recovery_ctrl

module tb_watchdog_recovery_ctrl;

    localparam int R = 4;
    localparam int G = 16;
    localparam int M = 3;
    localparam int H = 32;
    localparam int RW = $clog2(M + 1);

    logic          clk;
    logic          reset;
    logic          enable;
    logic          bark;
    logic          clear_fault;
    logic          wd_reset;
    logic          subsys_reset;
    logic          fault;
    logic [RW-1:0] retry_count;

    int checks = 0;
    int errors = 0;

    watchdog_recovery_ctrl #(
        .RESET_CYCLES  (R),
        .GRACE_CYCLES  (G),
        .MAX_RETRIES   (M),
        .HEALTHY_CYCLES(H)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .bark        (bark),
        .clear_fault (clear_fault),
        .wd_reset    (wd_reset),
        .subsys_reset(subsys_reset),
        .fault       (fault),
        .retry_count (retry_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: recovery is one window measured by elapsed cycles since
    // the accepted bark; the first R cycles of it drive subsys_reset.
    localparam int MD_IDLE = 0;
    localparam int MD_MON  = 1;
    localparam int MD_REC  = 2;
    localparam int MD_FLT  = 3;

    int m_mode    = MD_IDLE;
    int m_since   = 0;
    int m_retries = 0;
    int m_bfree   = 0;

    task automatic model_step(input bit rst, input bit en, input bit bk, input bit cf);
        if (rst) begin
            m_mode = MD_IDLE; m_since = 0; m_retries = 0; m_bfree = 0;
        end else begin
            case (m_mode)
                MD_IDLE: begin
                    m_bfree = 0;
                    if (en) m_mode = MD_MON;
                end
                MD_MON: begin
                    if (bk) begin
                        if (m_retries == M) m_mode = MD_FLT;
                        else begin
                            m_retries++; m_mode = MD_REC; m_since = 0;
                        end
                    end else if (!en) begin
                        m_mode = MD_IDLE; m_retries = 0;
                    end else begin
                        m_bfree++;
                        if (m_bfree == H) begin
                            m_retries = 0; m_bfree = 0;
                        end
                    end
                end
                MD_REC: begin
                    m_since++;
                    if (m_since == R + G) begin
                        m_bfree = 0;
                        if (en) m_mode = MD_MON;
                        else begin
                            m_mode = MD_IDLE; m_retries = 0;
                        end
                    end
                end
                default: begin
                    if (cf) begin
                        m_mode = MD_IDLE; m_retries = 0;
                    end
                end
            endcase
        end
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input bit rst, input bit en, input bit bk, input bit cf);
        logic [7:0] e_wd, e_sub, e_flt, e_rc;
        reset = rst; enable = en; bark = bk; clear_fault = cf;
        @(posedge clk);
        model_step(rst, en, bk, cf);
        #1;
        e_wd  = {7'd0, m_mode != MD_MON};
        e_sub = {7'd0, (m_mode == MD_REC && m_since < R) || m_mode == MD_FLT};
        e_flt = {7'd0, m_mode == MD_FLT};
        e_rc  = 8'(m_retries);
        check("wd_reset",     {7'd0, wd_reset},     e_wd);
        check("subsys_reset", {7'd0, subsys_reset}, e_sub);
        check("fault",        {7'd0, fault},        e_flt);
        check("retry_count",  {{(8-RW){1'b0}}, retry_count}, e_rc);
    endtask

    // Bark from MONITOR, then ride out the full recovery window with enable held.
    task automatic bark_and_recover();
        tick(0, 1, 1, 0);
        for (int i = 0; i < R + G; i++) tick(0, 1, 0, 0);
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; bark = 1'b0; clear_fault = 1'b0;

        // 1: reset, disabled period, then arm
        tick(1, 0, 0, 0);
        check("rst_wd",  {7'd0, wd_reset}, 8'd1);
        check("rst_sub", {7'd0, subsys_reset}, 8'd0);
        check("rst_flt", {7'd0, fault}, 8'd0);
        check("rst_rc",  {6'd0, 2'(retry_count)}, 8'd0);
        for (int i = 0; i < 10; i++) tick(0, 0, 0, 0);
        tick(0, 1, 0, 0);
        check("arm_wd", {7'd0, wd_reset}, 8'd0);

        // 2: single bark, bark during grace is ignored
        for (int i = 0; i < 3; i++) tick(0, 1, 0, 0);
        tick(0, 1, 1, 0);
        for (int i = 0; i < R; i++) begin
            check("rec_sub", {7'd0, subsys_reset}, 8'd1);
            tick(0, 1, 0, 0);
        end
        for (int i = 0; i < G; i++) begin
            check("grace_wd",  {7'd0, wd_reset}, 8'd1);
            check("grace_sub", {7'd0, subsys_reset}, 8'd0);
            tick(0, 1, (i == 5), 0);
        end
        check("back_wd", {7'd0, wd_reset}, 8'd0);
        check("back_rc", {6'd0, 2'(retry_count)}, 8'd1);

        // 3: repeated barks escalate to fault, clear_fault recovers
        tick(1, 0, 0, 0);
        tick(0, 1, 0, 0);
        for (int b = 1; b <= M; b++) begin
            for (int i = 0; i < 5; i++) tick(0, 1, 0, 0);
            bark_and_recover();
            check("esc_rc", {6'd0, 2'(retry_count)}, 8'(b));
        end
        for (int i = 0; i < 5; i++) tick(0, 1, 0, 0);
        tick(0, 1, 1, 0);
        for (int i = 0; i < 6; i++) tick(0, i[0], 1, 0);
        check("flt_flag", {7'd0, fault}, 8'd1);
        check("flt_sub",  {7'd0, subsys_reset}, 8'd1);
        tick(0, 1, 0, 1);
        check("clr_flt", {7'd0, fault}, 8'd0);
        check("clr_rc",  {6'd0, 2'(retry_count)}, 8'd0);

        // 4: healthy period clears retry_count; a bark on that cycle wins
        tick(0, 1, 0, 0);
        bark_and_recover();
        for (int i = 0; i < H - 1; i++) tick(0, 1, 0, 0);
        check("pre_heal_rc", {6'd0, 2'(retry_count)}, 8'd1);
        tick(0, 1, 0, 0);
        check("heal_rc", {6'd0, 2'(retry_count)}, 8'd0);
        bark_and_recover();
        for (int i = 0; i < H - 1; i++) tick(0, 1, 0, 0);
        tick(0, 1, 1, 0);
        check("heal_bark_rc",  {6'd0, 2'(retry_count)}, 8'd2);
        check("heal_bark_sub", {7'd0, subsys_reset}, 8'd1);
        for (int i = 0; i < R + G; i++) tick(0, 1, 0, 0);

        // 5: disable during recovery does not truncate it
        tick(0, 1, 1, 0);
        tick(0, 1, 0, 0);
        for (int i = 0; i < R + G - 1; i++) tick(0, 0, 0, 0);
        check("dis_wd", {7'd0, wd_reset}, 8'd1);
        check("dis_rc", {6'd0, 2'(retry_count)}, 8'd0);
        tick(0, 0, 0, 0);

        // 6: reset mid-grace and reset while faulted
        tick(0, 1, 0, 0);
        tick(0, 1, 1, 0);
        for (int i = 0; i < R + 10; i++) tick(0, 1, 0, 0);
        tick(1, 1, 0, 0);
        check("rg_wd", {7'd0, wd_reset}, 8'd1);
        check("rg_rc", {6'd0, 2'(retry_count)}, 8'd0);
        tick(0, 1, 0, 0);
        for (int b = 0; b <= M; b++) bark_and_recover();
        check("pre_rst_flt", {7'd0, fault}, 8'd1);
        tick(1, 1, 0, 0);
        check("rf_flt", {7'd0, fault}, 8'd0);
        check("rf_sub", {7'd0, subsys_reset}, 8'd0);
        tick(0, 1, 0, 0);
        check("rf_rearm", {7'd0, wd_reset}, 8'd0);

        // Randomized traffic against the model, busy then quiet bark rates
        for (int i = 0; i < 4000; i++) begin
            tick(($urandom_range(0, 299) == 0),
                 ($urandom_range(0, 19) != 0),
                 (i < 2000) ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 59) == 0),
                 ($urandom_range(0, 7) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
